// File: rtl/xpll.sv
// rtl/xpll.sv - soft PLL: lock timer, glitch-free fast-clock gate, even-ratio divider
// Everything runs off PLL_CLK_IN; the gate enable is the only falling-edge flop.
module xpll #(
  parameter int DIV_RATIO   = 4,
  parameter int LOCK_CYCLES = 256
) (
  input  logic PLL_CLK_IN,
  input  logic PLL_RST,
  output logic PLL_CLK_OUT,
  output logic PLL_CLK_DIV,
  output logic PLL_CLK_LOCKED
);

  localparam int CW = ($clog2(LOCK_CYCLES) < 1) ? 1 : $clog2(LOCK_CYCLES);
  localparam int PW = ($clog2(DIV_RATIO) < 1) ? 1 : $clog2(DIV_RATIO);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST    = PW'(DIV_RATIO - 1);
  localparam logic [PW-1:0] P_HALF    = PW'(DIV_RATIO / 2);

  if (DIV_RATIO < 2 || DIV_RATIO > 16 || (DIV_RATIO % 2) != 0) begin : g_bad_div
    $error("xpll: DIV_RATIO must be even and within 2..16");
  end
  if (LOCK_CYCLES < 2 || LOCK_CYCLES > 65536) begin : g_bad_lock
    $error("xpll: LOCK_CYCLES must be within 2..65536");
  end

  logic [CW-1:0] lock_cnt;
  logic          locked;
  logic [PW-1:0] p;
  logic          div;
  logic          en_n;

  // Counter stops at LOCK_LAST once lock is reached, so it never wraps.
  always_ff @(posedge PLL_CLK_IN) begin
    if (PLL_RST) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (!locked) begin
      if (lock_cnt == LOCK_LAST) begin
        locked <= 1'b1;
      end else begin
        lock_cnt <= lock_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge PLL_CLK_IN) begin
    if (PLL_RST || !locked) begin
      p   <= '0;
      div <= 1'b0;
    end else begin
      div <= (p < P_HALF);
      p   <= (p == P_LAST) ? '0 : p + PW'(1);
    end
  end

  // Sampling on the falling edge means the enable only changes while the
  // reference is low, so the AND gate can only pass whole high phases.
  always_ff @(negedge PLL_CLK_IN) begin
    en_n <= locked;
  end

  assign PLL_CLK_OUT    = PLL_CLK_IN & en_n;
  assign PLL_CLK_DIV    = div;
  assign PLL_CLK_LOCKED = locked;

endmodule

// File: tb/tb_xpll.sv
// tb/tb_xpll.sv - scoreboard bench for xpll across three parameter sets
`timescale 1ns/100ps
module tb_xpll;

  localparam int LCS[3] = '{256, 2, 16};
  localparam int DRS[3] = '{4, 2, 8};

  typedef struct packed {
    logic l;
    logic d;
    logic o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] lk;
  logic [2:0] dv;
  logic [2:0] ot;

  exp_t sbq[3][$];
  int   k[3]      = '{0, 0, 0};
  int   errors    = 0;
  int   checks    = 0;
  int   pulses[2] = '{0, 0};

  always #2.5 clk = ~clk;

  xpll #(.DIV_RATIO(4), .LOCK_CYCLES(256)) u_dut0 (
    .PLL_CLK_IN(clk), .PLL_RST(rst),
    .PLL_CLK_OUT(ot[0]), .PLL_CLK_DIV(dv[0]), .PLL_CLK_LOCKED(lk[0])
  );
  xpll #(.DIV_RATIO(2), .LOCK_CYCLES(2)) u_dut1 (
    .PLL_CLK_IN(clk), .PLL_RST(rst),
    .PLL_CLK_OUT(ot[1]), .PLL_CLK_DIV(dv[1]), .PLL_CLK_LOCKED(lk[1])
  );
  xpll #(.DIV_RATIO(8), .LOCK_CYCLES(16)) u_dut2 (
    .PLL_CLK_IN(clk), .PLL_RST(rst),
    .PLL_CLK_OUT(ot[2]), .PLL_CLK_DIV(dv[2]), .PLL_CLK_LOCKED(lk[2])
  );

  task automatic chk(input string name, input int inst, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got=%b want=%b", name, inst, $time, act, exp);
    end
  endtask

  task automatic pulse_chk(input int inst, input realtime w);
    checks++;
    pulses[inst]++;
    if (w < 2.45 || w > 2.55) begin
      errors++;
      $display("FAIL out_pulse_width inst%0d t=%0t got=%0.2fns want=2.50ns", inst, $time, w);
    end
  endtask

  // Model: k = rising edges since reset release. Lock at k >= LOCK_CYCLES;
  // divider phase counts from edge LOCK_CYCLES+1; OUT during this high phase
  // reflects the lock state before this edge.
  task automatic drive_edge(input bit r);
    exp_t e;
    bit   prev;
    @(negedge clk);
    rst = r;
    for (int i = 0; i < 3; i++) begin
      prev = (k[i] >= LCS[i]);
      if (r) k[i] = 0;
      else if (k[i] < 1000000) k[i]++;
      e.l = (k[i] >= LCS[i]);
      e.d = (k[i] > LCS[i]) && (((k[i] - LCS[i] - 1) % DRS[i]) < DRS[i] / 2);
      e.o = prev;
      sbq[i].push_back(e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    repeat (2) @(posedge clk);
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (sbq[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow inst%0d t=%0t got=empty want=entry", i, $time);
        end else begin
          e = sbq[i].pop_front();
          chk("locked", i, lk[i], e.l);
          chk("div", i, dv[i], e.d);
          chk("out", i, ot[i], e.o);
        end
      end
    end
  end

  initial begin : glitch0
    realtime t0;
    forever begin
      @(posedge ot[0]);
      t0 = $realtime;
      @(negedge ot[0]);
      pulse_chk(0, $realtime - t0);
    end
  end

  initial begin : glitch1
    realtime t0;
    forever begin
      @(posedge ot[1]);
      t0 = $realtime;
      @(negedge ot[1]);
      pulse_chk(1, $realtime - t0);
    end
  end

  initial begin : stim
    int n_run;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    repeat (2) drive_edge(1'b1);
    repeat (399) drive_edge(1'b0);
    drive_edge(1'b1);
    repeat (300) drive_edge(1'b0);
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(1, 3)) drive_edge(1'b1);
      n_run = $urandom_range(1, 400);
      repeat (n_run) drive_edge(1'b0);
    end
    for (int n = 0; n < 200; n++) begin
      drive_edge($urandom_range(0, 19) == 0);
    end
    repeat (1000) drive_edge(1'b1);
    repeat (280) drive_edge(1'b0);
    drive_edge(1'b1);
    repeat (20) drive_edge(1'b0);
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sbq[i].size() != 0) begin
        errors++;
        $display("FAIL sb_leftover inst%0d got=%0d want=0", i, sbq[i].size());
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pulses[i] == 0) begin
        errors++;
        $display("FAIL out_pulse_seen inst%0d got=0 want=>0", i);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
